// File: rtl/conv5x5_window_feeder.sv
// Raster pixel stream to 5x5 sliding windows (valid-only, no border padding).
// Four line buffers feed a 5x5 shift window; a single registered output stage holds each window.
module conv5x5_window_feeder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [DATA_W-1:0]     pix_data,
    input  logic                  pix_sof,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [25*DATA_W-1:0]  win_data,
    output logic                  frame_done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_cur;
    logic [RW-1:0] row_q, row_cur;
    logic          accept, last_col, last_row, complete;

    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] lb3 [IMG_W];
    logic [DATA_W-1:0] lb4 [IMG_W];

    logic [25*DATA_W-1:0] wnd_q, wnd_d;
    logic [5*DATA_W-1:0]  new_col;

    always_comb begin
        pix_ready = !win_valid || win_ready;
        accept    = pix_valid && pix_ready;
        // A start-of-frame pixel is always treated as (0,0), whatever the counters say.
        col_cur   = pix_sof ? '0 : col_q;
        row_cur   = pix_sof ? '0 : row_q;
        last_col  = (col_cur == ColLast);
        last_row  = (row_cur == RowLast);
        complete  = (row_cur >= RW'(4)) && (col_cur >= CW'(4));
        // Entry wr of the new column sits at [DATA_W*wr +: DATA_W]; wr=0 is the oldest row.
        new_col   = {pix_data, lb1[col_cur], lb2[col_cur], lb3[col_cur], lb4[col_cur]};
        wnd_d     = '0;
        for (int wr = 0; wr < 5; wr++) begin
            for (int wc = 0; wc < 4; wc++) begin
                wnd_d[DATA_W*(5*wr+wc) +: DATA_W] = wnd_q[DATA_W*(5*wr+wc+1) +: DATA_W];
            end
            wnd_d[DATA_W*(5*wr+4) +: DATA_W] = new_col[DATA_W*wr +: DATA_W];
        end
    end

    // Storage is not reset: completeness gating guarantees stale contents never reach win_data.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb4[col_cur] <= lb3[col_cur];
            lb3[col_cur] <= lb2[col_cur];
            lb2[col_cur] <= lb1[col_cur];
            lb1[col_cur] <= pix_data;
            wnd_q        <= wnd_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && last_col && last_row;
            if (accept) begin
                col_q     <= last_col ? '0 : col_cur + CW'(1);
                row_q     <= last_col ? (last_row ? '0 : row_cur + RW'(1)) : row_cur;
                win_valid <= complete;
                if (complete) begin
                    win_data <= wnd_d;
                end
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule
